pipeline_sequencer: RTL

Sequences the five pipeline registers of the forwarding core. It converts the hazard unit's `stall_o` code, plus instruction/data memory acknowledges and a debug halt request, into per-stage enable and flush strobes. It also owns the memory-wait timeout, the halt/drain handshake and two saturating performance counters. It sits between the hazard unit and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_sequencer_pkg.sv | 33 +++
 rtl/sat_counter.sv | 37 +++
 rtl/pipeline_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer_pkg
// Description : Shared types and constants for the pipeline sequencer. The
//               stall codes are shared with the hazard unit that produces
//               stall_o.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_sequencer_pkg;

    // Sequencer states. ST_DWAIT remembers the state it came from, either
    // ST_RUN or ST_DRAIN, so that it can return there.
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DWAIT  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERR    = 3'd4
    } seq_state_e;

    // Hazard codes from the hazard unit. Code 2'b11 is handled as a
    // load-use (data) hazard.
    localparam logic [1:0] STALL_NONE = 2'b00;
    localparam logic [1:0] STALL_DATA = 2'b01;
    localparam logic [1:0] STALL_CTRL = 2'b10;

    // Codes 01 and 11 both mean a load-use freeze, so bit 0 alone decides.
    function automatic logic is_load_use(input logic [1:0] code);
        return code[0];
    endfunction

endpackage : pipeline_sequencer_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that stops at all-ones instead of wrapping.
// Ports       : clk_i  - clock
//               rst_i  - asynchronous active-high reset (count to 0)
//               inc_i  - count one event this cycle
//               clr_i  - synchronous clear, wins over inc_i
//               cnt_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Turns the hazard code, memory acknowledges and the debug halt
//               request into load-enable and flush strobes for the PC, IF/ID,
//               ID/EX, EX/MEM and MEM/WB registers. Owns the data-memory wait
//               timeout, the halt/drain handshake and two saturating
//               performance counters.
// Ports       : clk_i, rst_i           - clock, async active-high reset
//               stall_i[1:0]           - hazard code (00 none, 01/11 load-use,
//                                        10 control redirect)
//               imem_ack_i             - fetch data valid this cycle
//               dmem_req_i/dmem_ack_i  - MEM-stage data access / completion
//               halt_req_i             - level request to halt and drain
//               halt_ack_o             - pipeline empty and halted
//               *_en_o                 - per-register load enables
//               *_flush_o              - load a bubble (with matching enable)
//               err_o                  - sticky data-memory timeout
//               stall_cnt_o            - freeze-cycle count
//               flush_cnt_o            - control-flush event count
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int DMEM_TIMEOUT = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           stall_i,
    input  logic                 imem_ack_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ack_i,
    input  logic                 halt_req_i,
    output logic                 halt_ack_o,
    output logic                 pc_en_o,
    output logic                 if_id_en_o,
    output logic                 id_ex_en_o,
    output logic                 ex_mem_en_o,
    output logic                 mem_wb_en_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    // Counter widths are kept at least one bit wide so small parameter
    // values (including a disabled timeout) still elaborate.
    localparam int c_WAIT_W  = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT);
    localparam int c_DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(DMEM_TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE   = c_WAIT_W'(1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

    seq_state_e           r_state;
    seq_state_e           r_ret;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic                 r_err;

    logic w_live;        // RUN or DRAIN: rules apply, new dmem waits can start
    logic w_rules;       // cycle on which the priority rules decide the strobes
    logic w_drain_ctx;   // DRAIN, or DWAIT that will return to DRAIN
    logic w_dwait_hold;  // DWAIT with no acknowledge: everything frozen
    logic w_rule1;
    logic w_rule2;
    logic w_rule3;
    logic w_rule4;
    logic w_stall_inc;

    // ------------------------------------------------------------------------
    // Rule decode
    // ------------------------------------------------------------------------
    assign w_live       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_rules      = w_live || ((r_state == ST_DWAIT) && dmem_ack_i);
    assign w_drain_ctx  = (r_state == ST_DRAIN) ||
                          ((r_state == ST_DWAIT) && (r_ret == ST_DRAIN));
    assign w_dwait_hold = (r_state == ST_DWAIT) && !dmem_ack_i;

    // Rule 1 cannot fire in DWAIT: there it would be the hold case instead.
    assign w_rule1 = w_live && dmem_req_i && !dmem_ack_i;
    assign w_rule2 = w_rules && !w_rule1 && is_load_use(stall_i);
    assign w_rule3 = w_rules && !w_rule1 && (stall_i == STALL_CTRL);
    assign w_rule4 = w_rules && !w_rule1 && !w_rule2 && !w_rule3 &&
                     (!imem_ack_i || w_drain_ctx);

    // ------------------------------------------------------------------------
    // Enable / flush strobes (combinational from state and inputs)
    // ------------------------------------------------------------------------
    always_comb begin
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;

        if (rst_i) begin
            // Hold every register and present bubbles while in reset.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (w_rules && !w_rule1) begin
            if (w_rule2) begin
                // Freeze the front end, let the load complete, and push a
                // bubble into EX/MEM behind it.
                ex_mem_en_o    = 1'b1;
                ex_mem_flush_o = 1'b1;
                mem_wb_en_o    = 1'b1;
            end else begin
                // Rules 3-5 all advance the back end. In DRAIN the control
                // redirect still loads the PC so the target survives halt.
                pc_en_o     = !w_rule4;
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
                if (w_rule3) begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end else if (w_rule4) begin
                    if_id_flush_o = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_ret       <= ST_RUN;
            r_wait_cnt  <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_DRAIN, ST_DWAIT: begin
                    if (w_rule1) begin
                        r_state    <= ST_DWAIT;
                        r_ret      <= r_state;
                        r_wait_cnt <= '0;
                    end else if (w_dwait_hold) begin
                        if ((DMEM_TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST)) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                        end
                    end else if (!w_drain_ctx) begin
                        // A halt seen on the DWAIT ack cycle is left for the
                        // following RUN cycle, hence the explicit RUN check.
                        if ((r_state == ST_RUN) && halt_req_i) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= c_DRAIN_LAST;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_DRAIN;
                        // Only cycles that really move MEM/WB forward count
                        // toward emptying the pipe.
                        if (mem_wb_en_o && !w_rule2) begin
                            if (r_drain_cnt == '0) begin
                                r_state <= ST_HALTED;
                            end else begin
                                r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (!halt_req_i) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // ERR is only left through reset.
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    assign halt_ack_o = (r_state == ST_HALTED);
    assign err_o      = r_err;

    // Freeze cycles caused by memory waits or load-use; fetch bubbles from a
    // missing imem ack are not counted.
    assign w_stall_inc = w_rule1 || w_rule2 || w_dwait_hold;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall_inc),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_rule3),
        .clr_i (1'b0),
        .cnt_o (flush_cnt_o)
    );

endmodule : pipeline_sequencer
`default_nettype wire
